// File: rtl/spi_flash_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// spi_flash_pkg
// Shared definitions for the SPI flash command sequencer: flash opcodes,
// the status-register busy bit and the sequencer FSM state encoding.
// ---------------------------------------------------------------------------
package spi_flash_pkg;

   localparam logic [7:0] CMD_READ     = 8'h03;
   localparam logic [7:0] CMD_PP       = 8'h02;
   localparam logic [7:0] CMD_WREN     = 8'h06;
   localparam logic [7:0] CMD_RDSR     = 8'h05;
   localparam int         STAT_WIP_BIT = 0;

   // Every state other than IDLE, GAP and FIN moves exactly one byte through
   // the engine; the SEND/WAIT split is carried by a separate phase bit.
   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_CMD, S_RA2, S_RA1, S_RA0, S_RD_DAT,
      S_WREN,
      S_WR_CMD, S_WA2, S_WA1, S_WA0, S_WR_DAT,
      S_POLL_CMD, S_POLL_DAT,
      S_GAP,
      S_FIN
   } state_t;

   function automatic logic is_byte_state(input state_t s);
      return !(s inside {S_IDLE, S_GAP, S_FIN});
   endfunction

endpackage

// File: rtl/spi_flash_sequencer_if.sv
// ---------------------------------------------------------------------------
// spi_flash_sequencer_if
// Bundles the CPU request/response signals and the byte-engine handshake of
// the SPI flash sequencer.
//   slave  : the sequencer (takes requests, drives the byte engine)
//   master : the environment (CPU request logic plus the byte engine)
// Signals:
//   i_req_valid/i_req_rw/i_req_addr/i_req_wdata  request (rw: 1 = read)
//   o_MemoryReady/o_rd_data/o_done/o_timeout_err CPU-side status
//   o_eng_start/o_eng_tx/o_eng_last              byte command to the engine
//   i_eng_done/i_eng_rx                          byte completion from engine
// ---------------------------------------------------------------------------
interface spi_flash_sequencer_if #(parameter int ADDR_W = 12);

   logic              i_req_valid;
   logic              i_req_rw;
   logic [ADDR_W-1:0] i_req_addr;
   logic [7:0]        i_req_wdata;

   logic              o_MemoryReady;
   logic [7:0]        o_rd_data;
   logic              o_done;
   logic              o_timeout_err;

   logic              o_eng_start;
   logic [7:0]        o_eng_tx;
   logic              o_eng_last;
   logic              i_eng_done;
   logic [7:0]        i_eng_rx;

   modport slave (
      input  i_req_valid, i_req_rw, i_req_addr, i_req_wdata,
      input  i_eng_done, i_eng_rx,
      output o_MemoryReady, o_rd_data, o_done, o_timeout_err,
      output o_eng_start, o_eng_tx, o_eng_last
   );

   modport master (
      output i_req_valid, i_req_rw, i_req_addr, i_req_wdata,
      output i_eng_done, i_eng_rx,
      input  o_MemoryReady, o_rd_data, o_done, o_timeout_err,
      input  o_eng_start, o_eng_tx, o_eng_last
   );

endinterface

// File: rtl/spi_flash_sequencer.sv
// ---------------------------------------------------------------------------
// spi_flash_sequencer
// Turns single-byte CPU read/write requests into SPI flash command sequences
// on a byte-level engine (the engine owns CS; o_eng_last releases it).
//   Read : READ 03, A2, A1, A0, dummy 00 (captures data byte)
//   Write: WREN 06 | PP 02, A2, A1, A0, data | (RDSR 05, 00) until WIP = 0
// The CPU is held (o_MemoryReady = 0) from acceptance until FIN.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   bus         spi_flash_sequencer_if.slave (request + engine handshake)
// Parameters:
//   ADDR_W    CPU-side address width, zero-extended to 24 bits
//   POLL_MAX  RDSR polls allowed before the write aborts with o_timeout_err
//   GAP_CYC   idle cycles inserted between CS-released transfers (>= 1)
// ---------------------------------------------------------------------------
module spi_flash_sequencer
   import spi_flash_pkg::*;
#(
   parameter int          ADDR_W   = 12,
   parameter logic [15:0] POLL_MAX = 16'd50000,
   parameter int          GAP_CYC  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   spi_flash_sequencer_if.slave  bus
);

   localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

   state_t      state, state_n;
   state_t      ret, ret_n;        // where GAP resumes
   logic        phase, phase_n;    // 0 = SEND (start pulse), 1 = WAIT
   logic [23:0] addr_q;
   logic [7:0]  wdata_q;
   logic [15:0] poll_cnt, poll_inc, gap_cnt;
   logic [7:0]  rd_data_q;
   logic        tmo_q;

   logic        byte_st, byte_done, accept, wip, poll_to, gap_end;

   assign byte_st   = is_byte_state(state);
   // done only counts while a byte is outstanding; strays elsewhere are dropped
   assign byte_done = byte_st && phase && bus.i_eng_done;
   assign accept    = (state == S_IDLE) && bus.i_req_valid;
   assign wip       = bus.i_eng_rx[STAT_WIP_BIT];
   assign poll_inc  = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
   assign poll_to   = (poll_inc == POLL_MAX);
   assign gap_end   = (gap_cnt == GAP_LAST);

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         ret   <= S_IDLE;
         phase <= 1'b0;
      end else begin
         state <= state_n;
         ret   <= ret_n;
         phase <= phase_n;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_n = state;
      ret_n   = ret;
      // SEND always lasts one cycle, WAIT lasts until the engine finishes
      phase_n = byte_st && !byte_done;
      unique case (state)
         S_IDLE: if (bus.i_req_valid) state_n = bus.i_req_rw ? S_RD_CMD : S_WREN;
         S_GAP:  if (gap_end) state_n = ret;
         S_FIN:  state_n = S_IDLE;
         default: begin
            if (byte_done) begin
               unique case (state)
                  S_RD_CMD:   state_n = S_RA2;
                  S_RA2:      state_n = S_RA1;
                  S_RA1:      state_n = S_RA0;
                  S_RA0:      state_n = S_RD_DAT;
                  S_RD_DAT:   state_n = S_FIN;
                  S_WREN:     begin state_n = S_GAP; ret_n = S_WR_CMD; end
                  S_WR_CMD:   state_n = S_WA2;
                  S_WA2:      state_n = S_WA1;
                  S_WA1:      state_n = S_WA0;
                  S_WA0:      state_n = S_WR_DAT;
                  S_WR_DAT:   begin state_n = S_GAP; ret_n = S_POLL_CMD; end
                  S_POLL_CMD: state_n = S_POLL_DAT;
                  S_POLL_DAT: begin
                     if (!wip || poll_to) state_n = S_FIN;
                     else begin
                        state_n = S_GAP;
                        ret_n   = S_POLL_CMD;
                     end
                  end
                  default:    state_n = state;
               endcase
            end
         end
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         poll_cnt  <= '0;
         gap_cnt   <= '0;
         rd_data_q <= '0;
         tmo_q     <= 1'b0;
      end else begin
         if (accept) begin
            addr_q   <= 24'(bus.i_req_addr[ADDR_W-1:0]);
            wdata_q  <= bus.i_req_wdata;
            poll_cnt <= '0;
            tmo_q    <= 1'b0;
         end
         // zero on every GAP entry, so each gap is a fresh GAP_CYC count
         gap_cnt <= (state == S_GAP) ? gap_cnt + 16'd1 : '0;
         if (byte_done && state == S_RD_DAT)
            rd_data_q <= bus.i_eng_rx;
         if (byte_done && state == S_POLL_DAT && wip) begin
            poll_cnt <= poll_inc;
            if (poll_to) tmo_q <= 1'b1;
         end
      end
   end

   // ---------------- outputs ----------------
   logic       start_c, last_c, done_c, ready_c;
   logic [7:0] tx_c;

   always_comb begin
      start_c = 1'b0;
      tx_c    = 8'h00;
      last_c  = 1'b0;
      done_c  = 1'b0;
      // acceptance drops ready in the same cycle the request is seen
      ready_c = reset || (state == S_IDLE && !bus.i_req_valid) || state == S_FIN;
      if (!reset) begin
         start_c = byte_st && !phase;
         done_c  = (state == S_FIN);
         unique case (state)
            S_RD_CMD:   tx_c = CMD_READ;
            S_WR_CMD:   tx_c = CMD_PP;
            S_RA2, S_WA2: tx_c = addr_q[23:16];
            S_RA1, S_WA1: tx_c = addr_q[15:8];
            S_RA0, S_WA0: tx_c = addr_q[7:0];
            S_RD_DAT:   begin tx_c = 8'h00;    last_c = 1'b1; end
            S_WREN:     begin tx_c = CMD_WREN; last_c = 1'b1; end
            S_WR_DAT:   begin tx_c = wdata_q;  last_c = 1'b1; end
            S_POLL_CMD: tx_c = CMD_RDSR;
            S_POLL_DAT: begin tx_c = 8'h00;    last_c = 1'b1; end
            default:    tx_c = 8'h00;
         endcase
      end
   end

   assign bus.o_eng_start   = start_c;
   assign bus.o_eng_tx      = tx_c;
   assign bus.o_eng_last    = last_c;
   assign bus.o_done        = done_c;
   assign bus.o_MemoryReady = ready_c;
   assign bus.o_rd_data     = rd_data_q;
   assign bus.o_timeout_err = tmo_q;

endmodule
